drac_l15_port_arbiter: RTL and testbench



---
 rtl/drac_pkg.sv | 21 ++
 rtl/drac_l15_port_arbiter_rr_arbiter.sv | 33 +++
 rtl/drac_l15_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_drac_l15_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared types and defaults for the L1-to-L1.5 request port arbiter.
// Included by the arbiter top and its round-robin sub-module.
package drac_pkg;

    localparam int L15ArbNumPorts       = 5;
    localparam int L15ArbPidWidth       = $clog2(L15ArbNumPorts);
    localparam int L15ArbMaxOutstanding = 4;
    localparam int L15ArbPayloadWidth   = 128;

    typedef logic [L15ArbPidWidth-1:0] l15_arb_pid_t;

    // Request payload layout as carried on one 128-bit port.
    typedef struct packed {
        logic [39:0] addr;
        logic [4:0]  rqtype;
        logic [2:0]  size;
        logic [63:0] data;
        logic [15:0] rsvd;
    } l15_arb_req_t;

endpackage

// File: rtl/drac_l15_port_arbiter_rr_arbiter.sv
// Round-robin pick: first requesting port at or after the pointer.
// Purely combinational; the pointer register lives in the parent.
import drac_pkg::*;

module rr_arbiter #(
    parameter int NumPorts = L15ArbNumPorts,
    parameter int PidWidth = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [PidWidth-1:0] ptr_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [PidWidth-1:0] gnt_idx_o,
    output logic                gnt_valid_o
);

    // Scan ports starting at the pointer, wrapping at NumPorts.
    always_comb begin
        int idx;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int k = 0; k < NumPorts; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = PidWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/drac_l15_port_arbiter.sv
// N-port request arbiter and pid-routed response demux towards L1.5.
// Optional perf counters are enabled with DRAC_L15_ARB_PERF_EN.
import drac_pkg::*;

module drac_l15_port_arbiter #(
    parameter int NumPorts       = L15ArbNumPorts,
    parameter int PayloadWidth   = L15ArbPayloadWidth,
    parameter int RespWidth      = 256,
    parameter int MaxOutstanding = L15ArbMaxOutstanding,
    parameter int WakeUpCntWidth = 16,
    parameter int PidWidth       = $clog2(NumPorts)
) (
    input  logic                           clk_i,
    input  logic                           reset_l,
    output logic                           core_rst_no,
    input  logic [NumPorts-1:0]            req_valid_i,
    output logic [NumPorts-1:0]            req_ready_o,
    input  logic [NumPorts*PayloadWidth-1:0] req_data_i,
    output logic                           l15_req_valid_o,
    input  logic                           l15_req_ready_i,
    output logic [PayloadWidth-1:0]        l15_req_data_o,
    output logic [PidWidth-1:0]            l15_req_pid_o,
    input  logic                           rtrn_valid_i,
    output logic                           rtrn_ready_o,
    input  logic [PidWidth-1:0]            rtrn_pid_i,
    input  logic                           rtrn_last_i,
    input  logic [RespWidth-1:0]           rtrn_data_i,
    output logic [NumPorts-1:0]            resp_valid_o,
    input  logic [NumPorts-1:0]            resp_ready_i,
    output logic [RespWidth-1:0]           resp_data_o,
    output logic                           err_o,
    output logic                           busy_o
`ifdef DRAC_L15_ARB_PERF_EN
    ,
    output logic [NumPorts*32-1:0]         perf_grant_cnt_o,
    output logic [31:0]                    perf_stall_cnt_o
`endif
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [WakeUpCntWidth-1:0] wake_cnt;
    logic                      wake_msb;
    logic [CntW-1:0]           outstanding [NumPorts];
    logic [NumPorts-1:0]       eligible;
    logic [NumPorts-1:0]       gnt_oh;
    logic [PidWidth-1:0]       gnt_idx;
    logic                      gnt_valid;
    logic [PidWidth-1:0]       rr_ptr;
    logic                      can_load;
    logic                      accept;
    logic                      pid_ok;
    logic                      hit_ready;
    logic                      hit_zero;
    logic                      rtrn_bad;
    logic                      any_out;

    assign wake_msb    = wake_cnt[WakeUpCntWidth-1];
    assign core_rst_no = wake_msb & reset_l;

    // Wake-up window: count until the MSB sets, then hold.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) wake_cnt <= '0;
        else if (!wake_msb) wake_cnt <= wake_cnt + 1'b1;
    end

    // A port competes only with a free credit and after wake-up.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumPorts; i++) begin
            eligible[i] = wake_msb & req_valid_i[i]
                        & (outstanding[i] < CntW'(MaxOutstanding));
        end
    end

    rr_arbiter #(
        .NumPorts (NumPorts),
        .PidWidth (PidWidth)
    ) u_rr (
        .req_i       (eligible),
        .ptr_i       (rr_ptr),
        .gnt_o       (gnt_oh),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign can_load    = !l15_req_valid_o | l15_req_ready_i;
    assign accept      = gnt_valid & can_load;
    assign req_ready_o = gnt_oh & {NumPorts{can_load}};

    // Output slot and round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            l15_req_valid_o <= 1'b0;
            l15_req_data_o  <= '0;
            l15_req_pid_o   <= '0;
            rr_ptr          <= '0;
        end else if (accept) begin
            l15_req_valid_o <= 1'b1;
            l15_req_data_o  <= req_data_i[gnt_idx*PayloadWidth +: PayloadWidth];
            l15_req_pid_o   <= gnt_idx;
            rr_ptr          <= (gnt_idx == PidWidth'(NumPorts - 1))
                             ? '0 : gnt_idx + 1'b1;
        end else if (l15_req_ready_i) begin
            l15_req_valid_o <= 1'b0;
        end
    end

    // Decode the return pid; out-of-range or creditless returns are dropped.
    always_comb begin
        pid_ok    = 1'b0;
        hit_ready = 1'b0;
        hit_zero  = 1'b1;
        for (int i = 0; i < NumPorts; i++) begin
            if (rtrn_pid_i == PidWidth'(i)) begin
                pid_ok    = 1'b1;
                hit_ready = resp_ready_i[i];
                hit_zero  = (outstanding[i] == '0);
            end
        end
        rtrn_bad     = rtrn_valid_i & (!pid_ok | hit_zero);
        rtrn_ready_o = rtrn_bad | (pid_ok & hit_ready);
        resp_valid_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            resp_valid_o[i] = rtrn_valid_i & !rtrn_bad
                            & (rtrn_pid_i == PidWidth'(i));
        end
    end

    assign resp_data_o = rtrn_data_i;

    // Per-port credits: +1 on accept, -1 on a last-beat return.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < NumPorts; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                unique case ({accept & gnt_oh[i],
                              resp_valid_o[i] & rtrn_ready_o & rtrn_last_i})
                    2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
                    2'b01:   outstanding[i] <= outstanding[i] - 1'b1;
                    default: outstanding[i] <= outstanding[i];
                endcase
            end
        end
    end

    // Sticky protocol error on any dropped return.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) err_o <= 1'b0;
        else if (rtrn_bad) err_o <= 1'b1;
    end

    // Busy while any credit is in use or the slot holds a request.
    always_comb begin
        any_out = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            any_out = any_out | (outstanding[i] != '0);
        end
        busy_o = any_out | l15_req_valid_o;
    end

`ifdef DRAC_L15_ARB_PERF_EN
    // Grant counters per port and an L1.5 back-pressure cycle counter.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            perf_grant_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                if (accept & gnt_oh[i]) begin
                    perf_grant_cnt_o[i*32 +: 32] <=
                        perf_grant_cnt_o[i*32 +: 32] + 32'd1;
                end
            end
            if (l15_req_valid_o & !l15_req_ready_i) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_drac_l15_port_arbiter.sv
// Directed bench for drac_l15_port_arbiter (default 5-port build).
// Vector table for arbitration plus hand sequences for corner cases.
module tb_drac_l15_port_arbiter;

    localparam int NP = 5;
    localparam int PW = 128;
    localparam int RW = 256;
    localparam int IW = 3;

    logic              clk_i = 1'b0;
    logic              reset_l;
    logic              core_rst_no;
    logic [NP-1:0]     req_valid_i;
    logic [NP-1:0]     req_ready_o;
    logic [NP*PW-1:0]  req_data_i;
    logic              l15_req_valid_o;
    logic              l15_req_ready_i;
    logic [PW-1:0]     l15_req_data_o;
    logic [IW-1:0]     l15_req_pid_o;
    logic              rtrn_valid_i;
    logic              rtrn_ready_o;
    logic [IW-1:0]     rtrn_pid_i;
    logic              rtrn_last_i;
    logic [RW-1:0]     rtrn_data_i;
    logic [NP-1:0]     resp_valid_o;
    logic [NP-1:0]     resp_ready_i;
    logic [RW-1:0]     resp_data_o;
    logic              err_o;
    logic              busy_o;

    drac_l15_port_arbiter dut (
        .clk_i           (clk_i),
        .reset_l         (reset_l),
        .core_rst_no     (core_rst_no),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_data_i      (req_data_i),
        .l15_req_valid_o (l15_req_valid_o),
        .l15_req_ready_i (l15_req_ready_i),
        .l15_req_data_o  (l15_req_data_o),
        .l15_req_pid_o   (l15_req_pid_o),
        .rtrn_valid_i    (rtrn_valid_i),
        .rtrn_ready_o    (rtrn_ready_o),
        .rtrn_pid_i      (rtrn_pid_i),
        .rtrn_last_i     (rtrn_last_i),
        .rtrn_data_i     (rtrn_data_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_data_o     (resp_data_o),
        .err_o           (err_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NP-1:0] req_valid;
        logic          l15_rdy;
        logic [NP-1:0] exp_ready;
        logic          exp_valid;
        logic [IW-1:0] exp_pid;
    } vec_t;

    vec_t          vecs [10];
    logic [PW-1:0] pay [NP];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc;
    int            viol;
    logic [PW-1:0] held;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pack_data();
        for (int i = 0; i < NP; i++) req_data_i[i*PW +: PW] = pay[i];
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            pay[i] = {32'hCAFE_0000 | 32'(i), 32'h1111_1111 * 32'(i + 1),
                      32'hA5A5_0000 + 32'(i), 32'h0BAD_F00D ^ 32'(i)};
        end
        //            valid     rdy  ready     vld  pid
        vecs[0] = '{5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
        vecs[1] = '{5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1};
        vecs[2] = '{5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2};
        vecs[3] = '{5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3};
        vecs[4] = '{5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4};
        vecs[5] = '{5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
        vecs[6] = '{5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2};
        vecs[7] = '{5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2};
        vecs[8] = '{5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2};
        vecs[9] = '{5'b00100, 1'b1, 5'b00000, 1'b0, 3'd0};

        reset_l         = 1'b0;
        req_valid_i     = 5'b11111;
        l15_req_ready_i = 1'b1;
        rtrn_valid_i    = 1'b0;
        rtrn_pid_i      = '0;
        rtrn_last_i     = 1'b0;
        rtrn_data_i     = '0;
        resp_ready_i    = '0;
        pack_data();
        #1;
        chk("rst_core_rst_no", 64'(core_rst_no), 64'd0);
        chk("rst_l15_valid", 64'(l15_req_valid_o), 64'd0);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rtrn_ready", 64'(rtrn_ready_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_l = 1'b1;

        // Wake-up window: gate must stay closed for 2^15 edges.
        cyc  = 0;
        viol = 0;
        while (!core_rst_no && cyc < 40000) begin
            step();
            cyc++;
            if (l15_req_valid_o) viol++;
            if (!core_rst_no && req_ready_o != '0) viol++;
        end
        chk("wake_cycles", 64'(cyc), 64'd32768);
        chk("wake_early_grant", 64'(viol), 64'd0);

        // Fairness rotation, then port 2 runs into its credit limit.
        for (int v = 0; v < 10; v++) begin
            req_valid_i     = vecs[v].req_valid;
            l15_req_ready_i = vecs[v].l15_rdy;
            #1;
            chk($sformatf("vec%0d_req_ready", v),
                64'(req_ready_o), 64'(vecs[v].exp_ready));
            step();
            chk($sformatf("vec%0d_l15_valid", v),
                64'(l15_req_valid_o), 64'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_pid", v),
                    64'(l15_req_pid_o), 64'(vecs[v].exp_pid));
            end
        end

        // One last-beat return to port 2 frees a credit for next cycle.
        rtrn_valid_i = 1'b1;
        rtrn_pid_i   = 3'd2;
        rtrn_last_i  = 1'b1;
        rtrn_data_i  = {4{64'hFEED_BEEF_0000_0002}};
        resp_ready_i = 5'b00100;
        #1;
        chk("ret2_resp_valid", 64'(resp_valid_o), 64'h04);
        chk("ret2_rtrn_ready", 64'(rtrn_ready_o), 64'd1);
        chk("ret2_resp_data", resp_data_o[63:0], 64'hFEED_BEEF_0000_0002);
        chk("ret2_still_full", 64'(req_ready_o), 64'd0);
        step();
        rtrn_valid_i = 1'b0;
        resp_ready_i = '0;
        #1;
        chk("ret2_reaccept", 64'(req_ready_o), 64'h04);
        step();
        chk("ret2_l15_valid", 64'(l15_req_valid_o), 64'd1);
        chk("ret2_pid", 64'(l15_req_pid_o), 64'd2);

        // Backpressure: slot holds, nobody else gets ready.
        held            = pay[2];
        l15_req_ready_i = 1'b0;
        req_valid_i     = 5'b11011;
        pay[2]          = ~pay[2];
        pack_data();
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_ready_o != '0) viol++;
            step();
            if (!l15_req_valid_o || l15_req_pid_o != 3'd2) viol++;
            if (l15_req_data_o != held) viol++;
        end
        chk("bp_hold_violations", 64'(viol), 64'd0);
        chk("bp_data_lo", l15_req_data_o[63:0], held[63:0]);
        chk("bp_data_hi", l15_req_data_o[127:64], held[127:64]);
        l15_req_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready_o), 64'h08);
        step();
        chk("bp_release_pid", 64'(l15_req_pid_o), 64'd3);
        chk("bp_release_data", l15_req_data_o[63:0], pay[3][63:0]);
        req_valid_i = '0;
        step();
        chk("bp_drained", 64'(l15_req_valid_o), 64'd0);

        // Port 1 to two credits, then accept and return in one cycle.
        req_valid_i = 5'b00010;
        #1;
        chk("same_pre_ready", 64'(req_ready_o), 64'h02);
        step();
        rtrn_valid_i = 1'b1;
        rtrn_pid_i   = 3'd1;
        rtrn_last_i  = 1'b1;
        resp_ready_i = 5'b00010;
        #1;
        chk("same_req_ready", 64'(req_ready_o), 64'h02);
        chk("same_resp_valid", 64'(resp_valid_o), 64'h02);
        step();
        rtrn_valid_i = 1'b0;
        resp_ready_i = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("same_credit%0d", k), 64'(req_ready_o),
                (k < 2) ? 64'h02 : 64'h00);
            step();
        end

        // Return to a nonexistent port is swallowed and flagged.
        req_valid_i  = '0;
        rtrn_valid_i = 1'b1;
        rtrn_pid_i   = 3'd7;
        resp_ready_i = 5'b11111;
        #1;
        chk("bad_rtrn_ready", 64'(rtrn_ready_o), 64'd1);
        chk("bad_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("bad_err_before", 64'(err_o), 64'd0);
        step();
        rtrn_valid_i = 1'b0;
        resp_ready_i = '0;
        chk("bad_err_after", 64'(err_o), 64'd1);
        step();
        chk("bad_err_sticky", 64'(err_o), 64'd1);
        chk("busy_active", 64'(busy_o), 64'd1);

        // Asynchronous reset while a request sits in the slot.
        req_valid_i     = 5'b00001;
        l15_req_ready_i = 1'b0;
        #1;
        chk("mid_req_ready", 64'(req_ready_o), 64'h01);
        step();
        chk("mid_l15_valid", 64'(l15_req_valid_o), 64'd1);
        #1;
        reset_l = 1'b0;
        #1;
        chk("arst_l15_valid", 64'(l15_req_valid_o), 64'd0);
        chk("arst_req_ready", 64'(req_ready_o), 64'd0);
        chk("arst_err", 64'(err_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_core_rst_no", 64'(core_rst_no), 64'd0);
        chk("arst_pid", 64'(l15_req_pid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
